// File: rtl/remote_arb_pkg.sv
// Shared types and constants for the remote command arbiter.
//   state_t         : transaction FSM encoding
//   TMO_CYCLES_DEF  : default response timeout in clock cycles
package remote_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SENT,
        WAIT_RESP,
        DONE
    } state_t;

    localparam int unsigned TMO_CYCLES_DEF = 2_000_000;

endpackage

// File: rtl/remote_cmd_arb.sv
// Two-requester round-robin arbiter in front of a remote command link.
// A granted 16-bit command is issued once, then the block waits for the
// link to report it sent and for a one-byte response, aborting with tmo=1
// if the whole exchange exceeds TMO_CYCLES.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req0/cmd0         : requester 0 level request and command
//   req1/cmd1         : requester 1 level request and command
//   done0/done1       : one-cycle completion pulses
//   resp_out, tmo     : response byte / timeout flag, valid with done, held
//   busy              : any state other than IDLE
//   send_cmd, cmd     : transmit strobe and registered command to the link
//   cmd_sent          : link finished transmitting the command
//   resp_rdy, resp    : link response strobe and byte
module remote_cmd_arb
    import remote_arb_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  resp_out,
    output logic        tmo,
    output logic        busy,
    output logic        send_cmd,
    output logic [15:0] cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp
);

    localparam int TW = $clog2(TMO_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    state_t        state_q, state_d;
    logic          grant_q, grant_d;     // 0 = requester 0, 1 = requester 1
    logic          last_q, last_d;       // requester served most recently
    logic [15:0]   cmd_q, cmd_d;
    logic          send_q, send_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [7:0]    resp_out_q, resp_out_d;
    logic          tmo_q, tmo_d;
    logic [TW-1:0] timer_q, timer_d;

    logic timer_hit;
    logic pick;
    logic finish;      // enter DONE this cycle
    logic abort;       // finish because of timeout

    assign timer_hit = (timer_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        send_d     = 1'b0;
        resp_out_d = resp_out_q;
        tmo_d      = tmo_q;
        timer_d    = timer_q;
        pick       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to whoever was not served last.
                    pick    = (req0 && req1) ? ~last_q : req1;
                    grant_d = pick;
                    cmd_d   = pick ? cmd1 : cmd0;
                    send_d  = 1'b1;          // strobe is visible during ISSUE
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_SENT;
            end
            WAIT_SENT: begin
                timer_d = timer_hit ? timer_q : timer_q + 1'b1;
                if (cmd_sent) begin
                    state_d = WAIT_RESP;
                end else if (timer_hit) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_hit ? timer_q : timer_q + 1'b1;
                // A response arriving on the timeout cycle still counts.
                if (resp_rdy) begin
                    finish = 1'b1;
                end else if (timer_hit) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d    = DONE;
            resp_out_d = abort ? 8'h00 : resp;
            tmo_d      = abort;
        end

        // Done pulses are registered so they line up with the DONE state.
        done0_d = finish && !grant_q;
        done1_d = finish &&  grant_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;      // requester 0 wins the first tie
            cmd_q      <= 16'h0000;
            send_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            resp_out_q <= 8'h00;
            tmo_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            send_q     <= send_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            resp_out_q <= resp_out_d;
            tmo_q      <= tmo_d;
            timer_q    <= timer_d;
        end
    end

    assign done0    = done0_q;
    assign done1    = done1_q;
    assign resp_out = resp_out_q;
    assign tmo      = tmo_q;
    assign busy     = (state_q != IDLE);
    assign send_cmd = send_q;
    assign cmd      = cmd_q;

endmodule

// File: doc/remote_cmd_arb.md
REMOTE_CMD_ARB -- requirements
Module: remote_cmd_arb

Interface
REQ-001 Parameter TMO_CYCLES, default 2_000_000, sets the cycles allowed from send_cmd to response before abort.
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high: rst  input  1  asynchronous active-high reset.
REQ-004 req0  input  1  requester 0 request; level, held until done0.
REQ-005 cmd0  input  16  requester 0 command; stable while req0 high.
REQ-006 req1  input  1  requester 1 request; level, held until done1.
REQ-007 cmd1  input  16  requester 1 command; stable while req1 high.
REQ-008 done0  output  1  one-cycle completion pulse to requester 0.
REQ-009 done1  output  1  one-cycle completion pulse to requester 1.
REQ-010 resp_out  output  8  response byte, valid in the done cycle and held until the next done.
REQ-011 tmo  output  1  high with done when the transaction aborted on timeout.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 send_cmd  output  1  one-cycle transmit strobe to the remote comm link.
REQ-014 cmd  output  16  registered command to the link; held from ISSUE until IDLE.
REQ-015 cmd_sent  input  1  link reports both bytes transmitted.
REQ-016 resp_rdy  input  1  link reports response byte received; single-cycle pulse.
REQ-017 resp  input  8  link response byte, valid with resp_rdy.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_SENT, WAIT_RESP and DONE.
REQ-019 IDLE: any req high -> latch the grant and capture the granted cmd into the cmd register -> ISSUE; no req -> stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: with req0 and req1 both high, grant the requester not granted last; with only one high, grant it.
REQ-021 ISSUE: assert send_cmd=1 for exactly one cycle, clear the timer -> WAIT_SENT.
REQ-022 WAIT_SENT: cmd_sent=1 -> WAIT_RESP; otherwise stay.
REQ-023 WAIT_RESP: resp_rdy=1 -> load resp into resp_out, clear tmo -> DONE.
REQ-024 Timer SHALL count up in WAIT_SENT and WAIT_RESP, width $clog2(TMO_CYCLES)+1, and saturate at TMO_CYCLES-1.
REQ-025 On reaching TMO_CYCLES-1 in either wait state: resp_out=8'h00, tmo=1 -> DONE.
REQ-026 If resp_rdy and the timeout occur in the same cycle, resp_rdy SHALL win (tmo=0, resp captured).
REQ-027 DONE: pulse done of the granted requester for one cycle, update last-grant -> IDLE.
REQ-028 done0/done1 SHALL be registered outputs and never high together.
REQ-029 Latency SHALL be: req sampled in IDLE at edge k -> send_cmd high in cycle k+1; resp_rdy at edge m -> done high in cycle m+1.
REQ-030 resp_rdy or cmd_sent outside the state that consumes it SHALL be ignored.
REQ-031 A requester dropping req mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-032 A requester SHALL NOT be re-granted in the cycle immediately after its done; the extra IDLE cycle lets it drop req.

Reset
REQ-033 rst high SHALL force, asynchronously: state=IDLE, send_cmd=0, cmd=16'h0000, done0=done1=0, tmo=0, busy=0, resp_out=8'h00, timer=0, last-grant=1 (so requester 0 wins the first tie).
REQ-034 Reset mid-transaction SHALL abandon it with no done pulse; the requester re-requests.

Structure
REQ-035 Package remote_arb_pkg SHALL hold the state enum typedef and the TMO_CYCLES default constant.
REQ-036 No sub-module is natural; arbitration, timer and FSM SHALL be inline, and the link is instantiated by the parent.

Verification
REQ-037 req0, cmd0=16'hA5C3; cmd_sent after 20 cycles; resp_rdy with resp=8'hA5 -> one send_cmd with cmd=16'hA5C3, done0 pulse, resp_out=8'hA5, tmo=0.
REQ-038 req0 and req1 high together after reset -> requester 0 served first, requester 1 second; repeat with both high -> requester 0 again after requester 1 (alternation).
REQ-039 TMO_CYCLES=100, cmd_sent but no resp_rdy -> done pulse 100 cycles after ISSUE with tmo=1, resp_out=8'h00.
REQ-040 resp_rdy coincident with the timeout cycle -> tmo=0, resp_out equals resp.
REQ-041 rst pulsed during WAIT_RESP -> all outputs at reset values immediately, no done pulse, and the next req is served normally.
